// File: rtl/pulse_scheduler.sv
// pulse_scheduler: round-robin sequencer for the shared output register.
// The LFM, PSK and NOISE generators take turns driving the register. Each
// grant issues one START strobe, then after the pulse length (or an abort)
// one STOP strobe. The scheduler then waits for the register's READY, with
// a timeout, and holds an idle gap before it arbitrates again.
// Every output is a flop loaded from next-state values, so output pulses
// line up with the state that produces them.
module pulse_scheduler #(
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned READY_TIMEOUT = 255,
  parameter int unsigned LEN_W         = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_LFM,
  input  logic             REQ_PSK,
  input  logic             REQ_NOISE,
  input  logic [LEN_W-1:0] LEN_LFM,
  input  logic [LEN_W-1:0] LEN_PSK,
  input  logic [LEN_W-1:0] LEN_NOISE,
  input  logic             ABORT,
  input  logic             OUT_READY,
  output logic [2:0]       GRANT,
  output logic             SIGN_LFM_START_CALC,
  output logic             SIGN_PSK_START_CALC,
  output logic             SIGN_NOISE_START_CALC,
  output logic             SIGN_LFM_STOP_CALC,
  output logic             SIGN_PSK_STOP_CALC,
  output logic             SIGN_NOISE_STOP_CALC,
  output logic             BUSY,
  output logic             TIMEOUT_ERR
);

  localparam int unsigned TW       = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT + 1) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam int unsigned GW       = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP,
    S_WAIT_RDY,
    S_GAP
  } state_e;

  typedef enum logic [1:0] {
    T_LFM   = 2'd0,
    T_PSK   = 2'd1,
    T_NOISE = 2'd2
  } type_e;

  state_e           state_q, state_d;
  type_e            type_q, type_d;
  type_e            ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] run_q, run_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [TW-1:0]    tcnt_inc;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             err_q, err_d;

  logic [2:0]       grant_q, grant_d;
  logic [2:0]       start_q, start_d;
  logic [2:0]       stop_q, stop_d;
  logic             busy_q, busy_d;

  logic [2:0]       req_vec;
  logic             found;
  type_e            win;
  type_e            win_next;
  logic [LEN_W-1:0] win_len;
  logic [2:0]       type_sel;

  assign req_vec  = {REQ_NOISE, REQ_PSK, REQ_LFM};
  assign tcnt_inc = tcnt_q + TW'(1);

  // Round-robin search: first active request at or after the pointer, wrapping.
  always_comb begin
    logic [2:0] s;
    logic [1:0] p;
    found = 1'b0;
    win   = ptr_q;
    s     = '0;
    p     = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      s = {1'b0, ptr_q} + 3'(i);
      if (s >= 3'd3) s = s - 3'd3;
      p = s[1:0];
      if (!found && req_vec[p]) begin
        found = 1'b1;
        win   = type_e'(p);
      end
    end
  end

  // Length of the winning request; a zero length still produces a one-cycle pulse.
  always_comb begin
    win_len  = LEN_LFM;
    win_next = T_PSK;
    case (win)
      T_LFM:   begin win_len = LEN_LFM;   win_next = T_PSK;   end
      T_PSK:   begin win_len = LEN_PSK;   win_next = T_NOISE; end
      T_NOISE: begin win_len = LEN_NOISE; win_next = T_LFM;   end
      default: begin win_len = LEN_LFM;   win_next = T_PSK;   end
    endcase
    if (win_len == '0) win_len = LEN_W'(1);
  end

  // Next-state and counter logic for the pulse sequence.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    run_d   = run_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (OUT_READY && found) begin
          type_d  = win;
          ptr_d   = win_next;
          len_d   = win_len;
          state_d = S_START;
        end
      end
      S_START: begin
        // A length-1 pulse has no RUN cycle, so STOP follows START directly.
        run_d = len_q - LEN_W'(1);
        if (len_q == LEN_W'(1)) state_d = S_STOP;
        else                    state_d = S_RUN;
      end
      S_RUN: begin
        run_d = run_q - LEN_W'(1);
        if (ABORT || run_q == LEN_W'(1)) state_d = S_STOP;
      end
      S_STOP: begin
        tcnt_d  = '0;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (OUT_READY) begin
          gcnt_d  = '0;
          state_d = S_GAP;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TW'(READY_TIMEOUT)) begin
            err_d   = 1'b1;
            gcnt_d  = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gcnt_q == GW'(GAP_LAST)) state_d = S_IDLE;
        else                         gcnt_d  = gcnt_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state.
  always_comb begin
    type_sel = 3'b001 << type_d;
    grant_d  = (state_d == S_START) ? type_sel : '0;
    start_d  = (state_d == S_START) ? type_sel : '0;
    stop_d   = (state_d == S_STOP)  ? type_sel : '0;
    busy_d   = (state_d != S_IDLE);
  end

  // Sequencer state, arbitration pointer and counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      type_q  <= T_LFM;
      ptr_q   <= T_LFM;
      len_q   <= '0;
      run_q   <= '0;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      run_q   <= run_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      err_q   <= err_d;
    end
  end

  // Output flops; the asynchronous reset drops any strobe at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      grant_q <= '0;
      start_q <= '0;
      stop_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
    end
  end

  assign GRANT                 = grant_q;
  assign SIGN_LFM_START_CALC   = start_q[0];
  assign SIGN_PSK_START_CALC   = start_q[1];
  assign SIGN_NOISE_START_CALC = start_q[2];
  assign SIGN_LFM_STOP_CALC    = stop_q[0];
  assign SIGN_PSK_STOP_CALC    = stop_q[1];
  assign SIGN_NOISE_STOP_CALC  = stop_q[2];
  assign BUSY                  = busy_q;
  assign TIMEOUT_ERR           = err_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler using the default parameters (GAP 4, timeout 255).
module tb_pulse_scheduler;

  localparam int unsigned LW = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ_LFM = 1'b0, REQ_PSK = 1'b0, REQ_NOISE = 1'b0;
  logic [LW-1:0] LEN_LFM = '0, LEN_PSK = '0, LEN_NOISE = '0;
  logic          ABORT = 1'b0, OUT_READY = 1'b0;
  logic [2:0]    GRANT;
  logic          SIGN_LFM_START_CALC, SIGN_PSK_START_CALC, SIGN_NOISE_START_CALC;
  logic          SIGN_LFM_STOP_CALC, SIGN_PSK_STOP_CALC, SIGN_NOISE_STOP_CALC;
  logic          BUSY, TIMEOUT_ERR;
  logic [5:0]    strb;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  pulse_scheduler #(.GAP_CYCLES(4), .READY_TIMEOUT(255), .LEN_W(LW)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_LFM(REQ_LFM), .REQ_PSK(REQ_PSK), .REQ_NOISE(REQ_NOISE),
    .LEN_LFM(LEN_LFM), .LEN_PSK(LEN_PSK), .LEN_NOISE(LEN_NOISE),
    .ABORT(ABORT), .OUT_READY(OUT_READY), .GRANT(GRANT),
    .SIGN_LFM_START_CALC(SIGN_LFM_START_CALC), .SIGN_PSK_START_CALC(SIGN_PSK_START_CALC),
    .SIGN_NOISE_START_CALC(SIGN_NOISE_START_CALC),
    .SIGN_LFM_STOP_CALC(SIGN_LFM_STOP_CALC), .SIGN_PSK_STOP_CALC(SIGN_PSK_STOP_CALC),
    .SIGN_NOISE_STOP_CALC(SIGN_NOISE_STOP_CALC),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  assign strb = {SIGN_NOISE_STOP_CALC, SIGN_PSK_STOP_CALC, SIGN_LFM_STOP_CALC,
                 SIGN_NOISE_START_CALC, SIGN_PSK_START_CALC, SIGN_LFM_START_CALC};

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and confirm at most one strobe is high.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    chk("strobe_exclusive", 32'($countones(strb) <= 1), 32'd1);
  endtask

  task automatic wait_grant(input int maxc, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (GRANT != 3'b000) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_stop(input int maxc, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (strb[5:3] != 3'b000) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t0, t1, r;
    bit ok;
    bit any;
    logic [2:0] exp_g [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    t0 = 0; t1 = 0; r = 0; ok = 1'b0; any = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_grant", 32'(GRANT), 32'd0);
    chk("rst_strobes", 32'(strb), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_timeout", 32'(TIMEOUT_ERR), 32'd0);

    // Single LFM pulse of length 10
    RESET = 1'b0; OUT_READY = 1'b1; REQ_LFM = 1'b1; LEN_LFM = 16'd10;
    wait_grant(10, t0, ok);
    chk("lfm_grant_seen", 32'(ok), 32'd1);
    chk("lfm_grant", 32'(GRANT), 32'b001);
    chk("lfm_start", 32'(strb), 32'b000001);
    chk("lfm_busy", 32'(BUSY), 32'd1);
    REQ_LFM = 1'b0;
    wait_stop(30, t1, ok);
    chk("lfm_stop_seen", 32'(ok), 32'd1);
    chk("lfm_stop", 32'(strb), 32'b001000);
    chk("lfm_len", 32'(t1 - t0), 32'd10);

    // Round-robin with all three requests held, READY delayed after each stop
    RESET = 1'b1; tick(); RESET = 1'b0;
    REQ_LFM = 1'b1; REQ_PSK = 1'b1; REQ_NOISE = 1'b1;
    LEN_LFM = 16'd2; LEN_PSK = 16'd2; LEN_NOISE = 16'd2;
    r = cyc;
    for (int g = 0; g < 4; g++) begin
      wait_grant(40, t0, ok);
      chk("rr_grant_seen", 32'(ok), 32'd1);
      chk("rr_grant", 32'(GRANT), 32'(exp_g[g]));
      if (g > 0) chk("rr_gap", 32'(t0 - r), 32'd6);
      wait_stop(10, t1, ok);
      chk("rr_stop_seen", 32'(ok), 32'd1);
      chk("rr_stop", 32'(strb[5:3]), 32'(exp_g[g]));
      chk("rr_len", 32'(t1 - t0), 32'd2);
      OUT_READY = 1'b0;
      tick(); tick(); tick();
      OUT_READY = 1'b1;
      r = cyc;
    end
    REQ_LFM = 1'b0; REQ_PSK = 1'b0; REQ_NOISE = 1'b0;

    // Zero length PSK pulse: STOP one cycle after START
    RESET = 1'b1; tick(); RESET = 1'b0;
    REQ_PSK = 1'b1; LEN_PSK = 16'd0;
    wait_grant(10, t0, ok);
    chk("psk0_grant_seen", 32'(ok), 32'd1);
    chk("psk0_grant", 32'(GRANT), 32'b010);
    REQ_PSK = 1'b0;
    wait_stop(10, t1, ok);
    chk("psk0_stop_seen", 32'(ok), 32'd1);
    chk("psk0_stop", 32'(strb), 32'b010000);
    chk("psk0_len", 32'(t1 - t0), 32'd1);

    // NOISE length 100 aborted during RUN cycle 20
    REQ_NOISE = 1'b1; LEN_NOISE = 16'd100;
    wait_grant(20, t0, ok);
    chk("abort_grant_seen", 32'(ok), 32'd1);
    chk("abort_grant", 32'(GRANT), 32'b100);
    REQ_NOISE = 1'b0;
    repeat (19) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_stop", 32'(strb), 32'b100000);
    chk("abort_when", 32'(cyc - t0), 32'd20);
    any = 1'b0;
    repeat (30) begin
      tick();
      if (strb != 6'b0 || GRANT != 3'b000) any = 1'b1;
    end
    chk("abort_quiet", 32'(any), 32'd0);
    chk("abort_idle", 32'(BUSY), 32'd0);

    // READY held low after STOP: timeout after 255 waiting cycles
    REQ_LFM = 1'b1; LEN_LFM = 16'd2;
    wait_grant(10, t0, ok);
    chk("to_grant_seen", 32'(ok), 32'd1);
    chk("to_grant", 32'(GRANT), 32'b001);
    REQ_LFM = 1'b0;
    wait_stop(10, t1, ok);
    chk("to_stop_seen", 32'(ok), 32'd1);
    OUT_READY = 1'b0;
    repeat (255) tick();
    chk("to_not_yet", 32'(TIMEOUT_ERR), 32'd0);
    tick();
    chk("to_set", 32'(TIMEOUT_ERR), 32'd1);
    repeat (6) tick();
    chk("to_back_idle", 32'(BUSY), 32'd0);
    OUT_READY = 1'b1;
    repeat (5) tick();
    chk("to_sticky", 32'(TIMEOUT_ERR), 32'd1);

    // Reset during RUN, then pointer restarts at LFM
    REQ_PSK = 1'b1; LEN_PSK = 16'd50;
    wait_grant(10, t0, ok);
    chk("rrun_grant_seen", 32'(ok), 32'd1);
    chk("rrun_grant", 32'(GRANT), 32'b010);
    REQ_PSK = 1'b0;
    repeat (5) tick();
    chk("rrun_busy", 32'(BUSY), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rrun_grant0", 32'(GRANT), 32'd0);
    chk("rrun_strobes0", 32'(strb), 32'd0);
    chk("rrun_busy0", 32'(BUSY), 32'd0);
    chk("rrun_timeout0", 32'(TIMEOUT_ERR), 32'd0);
    tick();
    RESET = 1'b0;
    REQ_LFM = 1'b1; REQ_PSK = 1'b1; REQ_NOISE = 1'b1;
    wait_grant(10, t0, ok);
    chk("post_rst_seen", 32'(ok), 32'd1);
    chk("post_rst_grant", 32'(GRANT), 32'b001);
    chk("post_rst_start", 32'(strb), 32'b000001);
    REQ_LFM = 1'b0; REQ_PSK = 1'b0; REQ_NOISE = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
